// File: rtl/apb_gpio_bank_if.sv
// APB slave bus bundle for the GPIO bank.
// Master drives address/controls, slave returns data/ready/error.
interface apb_gpio_bank_if;
  logic [31:0] Paddr;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic [3:0]  Pstrb;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Paddr, Psel, Penable, Pwrite, Pwdata, Pstrb,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Paddr, Psel, Penable, Pwrite, Pwdata, Pstrb,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: byte-strobed output registers, synchronized inputs,
// per-channel change interrupts with W1C status and enable mask.
module apb_gpio_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          N_OUT       = 2,
  parameter int          N_IN        = 2,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic                Pclk,
  input  logic                Prst,
  apb_gpio_bank_if.slave      bus,
  output logic [32*N_OUT-1:0] gpio_out,
  input  logic [32*N_IN-1:0]  gpio_in,
  output logic                irq
);

  localparam logic [31:0] IN_MASK =
    32'((64'd1 << N_IN) - 64'd1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [5:0] OUT_END = 6'(N_OUT);
  localparam logic [5:0] IN_BEG = 6'd16;
  localparam logic [5:0] IN_END = 6'(16 + N_IN);
  localparam logic [5:0] ST_W = 6'd48;
  localparam logic [5:0] EN_W = 6'd49;

  logic [31:0] out_q  [N_OUT];
  logic [31:0] s1_q   [N_IN];
  logic [31:0] s2_q   [N_IN];
  logic [31:0] prev_q [N_IN];
  logic [31:0] stat_q;
  logic [31:0] en_q;
  logic [3:0]  wait_q;
  logic        abort_q;
  logic [1:0]  arm_q;
  logic        irq_q;

  logic [31:0] off;
  logic [5:0]  word;
  logic        in_win;
  logic        aligned;
  logic        hit_out;
  logic        hit_in;
  logic        hit_st;
  logic        hit_en;
  logic        hit_irq;
  logic        bad;
  logic        access;
  logic        ready;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] bmask;
  logic [31:0] out_rd;
  logic [31:0] in_rd;
  logic [31:0] rdata;
  logic [31:0] chg;
  logic [31:0] set_v;
  logic [31:0] clr_v;
  logic        armed;

  assign off     = bus.Paddr - BASE_ADDR;
  assign word    = off[7:2];
  assign in_win  = (off[31:8] == 24'd0);
  assign aligned = (off[1:0] == 2'd0);

  assign hit_out = in_win && (word < OUT_END);
  assign hit_in  = in_win && (word >= IN_BEG)
                   && (word < IN_END);
  assign hit_st  = in_win && (word == ST_W);
  assign hit_en  = in_win && (word == EN_W);
  assign hit_irq = hit_st || hit_en;

  // Any decode problem turns the completing beat into an error beat.
  always_comb begin
    bad = 1'b0;
    if (!in_win || !aligned)
      bad = 1'b1;
    else if (!(hit_out || hit_in || hit_irq))
      bad = 1'b1;
    else if (bus.Pwrite && hit_in)
      bad = 1'b1;
    else if (bus.Pwrite && hit_irq && bus.Pstrb != 4'hF)
      bad = 1'b1;
  end

  assign access = bus.Psel && bus.Penable;
  assign ready  = access && !abort_q && (wait_q == WS);
  assign wr_en  = ready && bus.Pwrite && !bad;
  assign rd_en  = ready && !bus.Pwrite && !bad;

  assign bus.Pready  = ready;
  assign bus.Pslverr = ready && bad;
  assign bus.Prdata  = rd_en ? rdata : 32'h0;

  assign bmask = {{8{bus.Pstrb[3]}}, {8{bus.Pstrb[2]}},
                  {8{bus.Pstrb[1]}}, {8{bus.Pstrb[0]}}};

  // Select the addressed output register.
  always_comb begin
    out_rd = '0;
    for (int i = 0; i < N_OUT; i++)
      if (word == 6'(i)) out_rd = out_q[i];
  end

  // Select the addressed synchronized input channel.
  always_comb begin
    in_rd = '0;
    for (int j = 0; j < N_IN; j++)
      if (word == 6'(16 + j)) in_rd = s2_q[j];
  end

  // Read mux; registers hold pre-write values during the beat.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_out: rdata = out_rd;
      hit_in:  rdata = in_rd;
      hit_st:  rdata = stat_q;
      hit_en:  rdata = en_q;
      default: rdata = '0;
    endcase
  end

  // Wait counter; abort keeps Pready low after reset until the bus idles.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      wait_q  <= '0;
      abort_q <= 1'b1;
    end else begin
      if (!access) abort_q <= 1'b0;
      if (!access || ready || abort_q)
        wait_q <= '0;
      else
        wait_q <= wait_q + 4'd1;
    end
  end

  // Output registers with byte-strobed writes.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      for (int i = 0; i < N_OUT; i++)
        out_q[i] <= OUT_RESET;
    end else if (wr_en && hit_out) begin
      for (int i = 0; i < N_OUT; i++)
        if (word == 6'(i))
          out_q[i] <= (out_q[i] & ~bmask)
                    | (bus.Pwdata & bmask);
    end
  end

  // Drive output bus from the register array.
  always_comb begin
    gpio_out = '0;
    for (int i = 0; i < N_OUT; i++)
      gpio_out[32*i +: 32] = out_q[i];
  end

  // Two-flop synchronizer plus previous-value stage per input bit.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      for (int j = 0; j < N_IN; j++) begin
        s1_q[j]   <= '0;
        s2_q[j]   <= '0;
        prev_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_IN; j++) begin
        s1_q[j]   <= gpio_in[32*j +: 32];
        s2_q[j]   <= s1_q[j];
        prev_q[j] <= s2_q[j];
      end
    end
  end

  // Arm counter blanks change detection while the pipeline refills.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst)
      arm_q <= '0;
    else if (arm_q != 2'd3)
      arm_q <= arm_q + 2'd1;
  end

  assign armed = (arm_q == 2'd3);

  // Per-channel change flags.
  always_comb begin
    chg = '0;
    for (int j = 0; j < N_IN; j++)
      chg[j] = |(s2_q[j] ^ prev_q[j]);
  end

  assign set_v = armed ? chg : 32'h0;
  assign clr_v = (wr_en && hit_st)
               ? (bus.Pwdata & IN_MASK) : 32'h0;

  // Status: W1C clear, a same-cycle change set takes priority.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst)
      stat_q <= '0;
    else
      stat_q <= (stat_q & ~clr_v) | set_v;
  end

  // Interrupt enable mask, only implemented channels stored.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst)
      en_q <= '0;
    else if (wr_en && hit_en)
      en_q <= bus.Pwdata & IN_MASK;
  end

  // Registered level interrupt.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst)
      irq_q <= 1'b0;
    else
      irq_q <= |(stat_q & en_q);
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Testbench for apb_gpio_bank: directed cases plus random APB
// traffic against a register-level model of the bank.
module tb_apb_gpio_bank;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          NO    = 2;
  localparam int          NI    = 2;
  localparam logic [31:0] ORST  = 32'h0F0F_0F0F;
  localparam logic [31:0] IMASK = 32'h3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pwrite, penable, psel0, psel3;
  logic [63:0] gin, gout0, gout3;
  logic        irq0, irq3;

  apb_gpio_bank_if b0 ();
  apb_gpio_bank_if b3 ();

  assign b0.Paddr   = paddr;
  assign b0.Psel    = psel0;
  assign b0.Penable = penable;
  assign b0.Pwrite  = pwrite;
  assign b0.Pwdata  = pwdata;
  assign b0.Pstrb   = pstrb;
  assign b3.Paddr   = paddr;
  assign b3.Psel    = psel3;
  assign b3.Penable = penable;
  assign b3.Pwrite  = pwrite;
  assign b3.Pwdata  = pwdata;
  assign b3.Pstrb   = pstrb;

  apb_gpio_bank #(
    .BASE_ADDR(BASE), .N_OUT(NO), .N_IN(NI),
    .WAIT_STATES(0), .OUT_RESET(ORST)
  ) dut0 (
    .Pclk(clk), .Prst(rst0), .bus(b0),
    .gpio_out(gout0), .gpio_in(gin), .irq(irq0)
  );

  apb_gpio_bank #(
    .BASE_ADDR(BASE), .N_OUT(NO), .N_IN(NI),
    .WAIT_STATES(3), .OUT_RESET(32'h0)
  ) dut3 (
    .Pclk(clk), .Prst(rst3), .bus(b3),
    .gpio_out(gout3), .gpio_in(gin), .irq(irq3)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference model of dut0.
  logic [31:0] m_out [NO];
  logic [31:0] m_stat, m_en;
  logic        m_irq;
  logic [63:0] h [3];
  int          age;
  logic        p_v;
  logic [31:0] p_off, p_data;
  logic [3:0]  p_strb;
  logic        mon;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] changes(input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < NI; j++)
      r[j] = (a[32*j +: 32] != b[32*j +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] clr_now();
    if (p_v && p_off == 32'hC0) return p_data & IMASK;
    return 32'h0;
  endfunction

  // h[0..2]: input as seen one, two, three samples back.
  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      for (int i = 0; i < NO; i++) m_out[i] <= ORST;
      m_stat <= '0;
      m_en   <= '0;
      m_irq  <= 1'b0;
      for (int k = 0; k < 3; k++) h[k] <= '0;
      age <= 0;
    end else begin
      m_stat <= (m_stat & ~clr_now())
              | ((age >= 3) ? changes(h[1], h[2]) : 32'h0);
      if (p_v && p_off == 32'hC4) m_en <= p_data & IMASK;
      for (int i = 0; i < NO; i++)
        if (p_v && p_off == 32'(4*i))
          m_out[i] <= merge(m_out[i], p_data, p_strb);
      m_irq <= |(m_stat & m_en);
      h[0] <= gin;
      h[1] <= h[0];
      h[2] <= h[1];
      if (age < 3) age <= age + 1;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      check("irq", 64'(irq0), 64'(m_irq));
      check("gpio_out", gout0, {m_out[1], m_out[0]});
    end
  end

  task automatic xfer0(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd_o, output logic se_o);
    logic [31:0] off, rd;
    logic err;
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    psel0 = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    off = a - BASE;
    err = 1'b1;
    rd = '0;
    for (int i = 0; i < NO; i++)
      if (off == 32'(4*i)) begin err = 1'b0; rd = m_out[i]; end
    for (int j = 0; j < NI; j++)
      if (off == 32'(64 + 4*j)) begin
        err = w; rd = h[1][32*j +: 32];
      end
    if (off == 32'hC0) begin err = w && (s != 4'hF); rd = m_stat; end
    if (off == 32'hC4) begin err = w && (s != 4'hF); rd = m_en; end
    rd_o = b0.Prdata;
    se_o = b0.Pslverr;
    check("pready", 64'(b0.Pready), 64'(1'b1));
    check("pslverr", 64'(se_o), 64'(err));
    check("prdata", 64'(rd_o), 64'((!w && !err) ? rd : 32'h0));
    if (w && !err) begin
      p_off = off; p_data = d; p_strb = s; p_v = 1'b1;
    end
    @(negedge clk);
    p_v = 1'b0;
    psel0 = 1'b0;
    penable = 1'b0;
  endtask

  task automatic xfer3(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd_o, output logic se_o,
                       output int waits);
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    psel3 = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!b3.Pready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rd_o = b3.Prdata;
    se_o = b3.Pslverr;
    @(negedge clk);
    psel3 = 1'b0;
    penable = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return BASE + 4 * $urandom_range(0, NO - 1);
      3:       return BASE + 32'h40 + 4 * $urandom_range(0, NI - 1);
      4:       return BASE + 32'hC0;
      5:       return BASE + 32'hC4;
      6:       return BASE + $urandom_range(0, 255);
      7:       return BASE + 4 * $urandom_range(0, 63);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, d;
    logic        se, w;
    logic [3:0]  s;
    int          ws, first, ch;

    rst0 = 1'b0; rst3 = 1'b0; mon = 1'b0; p_v = 1'b0;
    p_off = '0; p_data = '0; p_strb = '0;
    paddr = '0; pwdata = '0; pstrb = '0; pwrite = 1'b0;
    psel0 = 1'b1; psel3 = 1'b0; penable = 1'b1;
    gin = {$urandom, $urandom} | 64'h0000_0001_0000_0001;
    #1;
    rst0 = 1'b1; rst3 = 1'b1;
    #1;
    check("rst_out0", gout0, {ORST, ORST});
    check("rst_out3", gout3, 64'h0);
    check("rst_irq", 64'(irq0), 64'h0);
    check("rst_rdy", 64'(b0.Pready), 64'h0);
    repeat (3) @(negedge clk);
    psel0 = 1'b0; penable = 1'b0;
    rst0 = 1'b0; rst3 = 1'b0;
    mon = 1'b1;

    // Inputs nonzero through reset release must not flag a change.
    repeat (8) @(negedge clk);
    xfer0(BASE + 32'hC4, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, se);
    xfer0(BASE + 32'hC0, 1'b0, 32'h0, 4'h0, rd, se);
    check("arm_quiet", 64'(rd), 64'h0);
    check("irq_quiet", 64'(irq0), 64'h0);

    xfer0(BASE, 1'b1, 32'hA5A5_A5A5, 4'hF, rd, se);
    check("wr_a5", 64'(gout0[31:0]), 64'hA5A5_A5A5);

    xfer0(BASE, 1'b1, 32'h0, 4'hF, rd, se);
    xfer0(BASE, 1'b1, 32'hFFFF_FFFF, 4'b0010, rd, se);
    check("strb", 64'(gout0[31:0]), 64'h0000_FF00);

    xfer0(BASE + 32'h40, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, se);
    check("err_in_wr", 64'(se), 64'h1);
    xfer0(BASE + 32'h3C, 1'b0, 32'h0, 4'hF, rd, se);
    check("err_hole", 64'(se), 64'h1);
    xfer0(BASE + 32'h01, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, se);
    check("err_mis", 64'(se), 64'h1);
    xfer0(BASE + 32'hC4, 1'b1, 32'h0, 4'h3, rd, se);
    check("err_irq_strb", 64'(se), 64'h1);
    check("err_keep", gout0, {ORST, 32'h0000_FF00});
    xfer0(BASE + 32'hC4, 1'b0, 32'h0, 4'h0, rd, se);
    check("en_keep", 64'(rd), 64'h3);

    // Channel 1 change -> status, then irq one cycle later.
    xfer0(BASE + 32'hC4, 1'b1, 32'h2, 4'hF, rd, se);
    gin[63:32] = 32'h0;
    repeat (6) @(negedge clk);
    xfer0(BASE + 32'hC0, 1'b1, 32'h3, 4'hF, rd, se);
    repeat (2) @(negedge clk);
    check("irq_idle", 64'(irq0), 64'h0);
    gin[63:32] = 32'h5;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) check("stat_2cyc", 64'(dut0.stat_q), 64'h0);
      if (k == 3) check("stat_3cyc", 64'(dut0.stat_q), 64'h2);
      if (irq0 && first == 0) first = k;
    end
    check("irq_lat", 64'(first), 64'd4);
    xfer0(BASE + 32'hC0, 1'b1, 32'h2, 4'hF, rd, se);
    check("irq_hold", 64'(irq0), 64'h1);
    @(negedge clk);
    check("irq_drop", 64'(irq0), 64'h0);
    // New value reaches the detector on the W1C commit edge.
    gin[63:32] = 32'h7;
    xfer0(BASE + 32'hC0, 1'b1, 32'h2, 4'hF, rd, se);
    xfer0(BASE + 32'hC0, 1'b0, 32'h0, 4'hF, rd, se);
    check("set_wins", 64'(rd), 64'h2);
    xfer0(BASE + 32'hC0, 1'b1, 32'h3, 4'hF, rd, se);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = int'($urandom_range(0, NI - 1));
        gin[32*ch +: 32] = $urandom;
      end
      a = rnd_addr();
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      xfer0(a, w, d, s, rd, se);
    end

    // Wait-state instance.
    xfer3(BASE + 32'h4, 1'b1, 32'h1234, 4'hF, rd, se, ws);
    check("ws_wr", 64'(ws), 64'd3);
    check("ws_wr_err", 64'(se), 64'h0);
    check("ws_out1", 64'(gout3[63:32]), 64'h1234);
    xfer3(BASE + 32'h4, 1'b0, 32'h0, 4'hF, rd, se, ws);
    check("ws_rd", 64'(ws), 64'd3);
    check("ws_rdata", 64'(rd), 64'h1234);

    // Reset pulse in the middle of a waited write.
    @(negedge clk);
    paddr = BASE; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    pstrb = 4'hF; psel3 = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1 rst3 = 1'b1;
    #2;
    check("rst_mid_out", gout3, 64'h0);
    rst3 = 1'b0;
    first = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (b3.Pready) first++;
    end
    check("rst_no_rdy", 64'(first), 64'h0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rst_no_commit", gout3, 64'h0);
    xfer3(BASE, 1'b1, 32'h55, 4'hF, rd, se, ws);
    check("ws_fresh", 64'(ws), 64'd3);
    check("ws_fresh_out", gout3, 64'h55);

    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
